fetch_buf: RTL

Instruction prefetch buffer between the instruction memory and the decode stage. It owns the fetch address, drives it to the instruction memory, captures the returned instruction with its address into a small FIFO, and presents entries to decode through a valid/ready handshake. Jumps and hazards redirect fetch through a flush, and the end-of-program indication stops further fetching.

---
 rtl/fetch_buf.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf -- instruction prefetch buffer
//
// Owns the fetch program counter and drives it to a combinational instruction
// memory. Each cycle in which there is room (or room being made by a
// same-cycle pop), the returned instruction is captured together with its
// address into a small circular FIFO. The FIFO head is offered to the decode
// stage through a valid/ready handshake.
//
// A flush discards every buffered entry and redirects fetch to a new address.
// The end-of-program indication sets a sticky halted flag that stops all
// further fetching. Buffered entries still drain. Only reset clears the flag.
//
// Parameters
//   DEPTH  number of FIFO entries (power of two, >= 2)
//   IW     instruction width
//   AW     fetch address width
//
// Ports
//   clk_i      in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   flush_i    in   discard buffered entries and load jmp_adr_i as the new PC
//   jmp_adr_i  in   redirect target, sampled while flush_i = 1
//   end_pr_i   in   end of program; halts fetching from the next edge on
//   adr_o      out  fetch address (current PC)
//   instr_i    in   instruction stored at adr_o, same cycle
//   instr_o    out  head-entry instruction (0 when empty)
//   pc_o       out  head-entry address (0 when empty)
//   valid_o    out  head entry valid (forced low during a flush)
//   ready_i    in   decode accepts the head entry
//   level_o    out  number of occupied entries
// -----------------------------------------------------------------------------
module fetch_buf #(
    parameter int DEPTH = 4,
    parameter int IW    = 16,
    parameter int AW    = 16,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst,
    input  logic          flush_i,
    input  logic [AW-1:0] jmp_adr_i,
    input  logic          end_pr_i,
    output logic [AW-1:0] adr_o,
    input  logic [IW-1:0] instr_i,
    output logic [IW-1:0] instr_o,
    output logic [AW-1:0] pc_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [LW-1:0] level_o
);

    // Pointer width. DEPTH is a power of two, so the pointers wrap naturally.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [AW-1:0] pc_reg;
    logic [AW-1:0] pc_next;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] wr_ptr_next;
    logic [LW-1:0] level_reg;
    logic [LW-1:0] level_next;
    logic          halted_reg;
    logic          halted_next;

    // FIFO storage: address and instruction of each fetched entry. The arrays
    // carry no reset. After reset the level is zero, and the outputs are
    // masked to zero until an entry has been written.
    logic [AW-1:0] adr_mem [DEPTH];
    logic [IW-1:0] ins_mem [DEPTH];

    // -------------------------------------------------------------------------
    // Handshake and fetch decisions
    // -------------------------------------------------------------------------
    logic not_empty;
    logic not_full;
    logic pop;
    logic push;

    assign not_empty = (level_reg != '0);
    assign not_full  = (level_reg != LW'(DEPTH));

    // The flush gate is the only combinational term on valid_o. No transfer
    // can happen in a flush cycle, because the flush throws the entry away.
    assign valid_o = not_empty && !flush_i;
    assign pop     = valid_o && ready_i;

    // A full FIFO may still accept a fetch when the head leaves in the same
    // cycle. This keeps throughput at one entry per cycle under a steady
    // ready_i. end_pr_i blocks the fetch in its own cycle, before halted is set.
    assign push = !flush_i && !halted_reg && !end_pr_i && (not_full || pop);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        pc_next     = pc_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        level_next  = level_reg;
        // The halted flag is sticky. A flush does not clear it.
        halted_next = halted_reg | end_pr_i;

        if (flush_i) begin
            // A redirect overrides everything else: the buffer empties and
            // fetch restarts at the jump target on the next cycle.
            pc_next     = jmp_adr_i;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            level_next  = '0;
        end else begin
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
                // The PC wraps from all-ones back to zero.
                pc_next     = pc_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_next = level_reg + LW'(1);
                2'b01:   level_next = level_reg - LW'(1);
                default: level_next = level_reg;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            pc_reg     <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            level_reg  <= '0;
            halted_reg <= 1'b0;
        end else begin
            pc_reg     <= pc_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            level_reg  <= level_next;
            halted_reg <= halted_next;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO array write: capture {fetch address, instruction} at the write slot
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (push) begin
            adr_mem[wr_ptr_reg] <= pc_reg;
            ins_mem[wr_ptr_reg] <= instr_i;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign adr_o   = pc_reg;
    assign level_o = level_reg;

    // The head is read straight from the registered pointer and array. No
    // path exists from ready_i or instr_i to these outputs. The head stays
    // stable until it is popped, flushed or reset.
    assign pc_o    = not_empty ? adr_mem[rd_ptr_reg] : '0;
    assign instr_o = not_empty ? ins_mem[rd_ptr_reg] : '0;

endmodule
